// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// Also used by the single-cycle decoder for immediate selection.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_TRAP
  } statetype_e;

  localparam logic [6:0] OP_R   = 7'd51;
  localparam logic [6:0] OP_I   = 7'd19;
  localparam logic [6:0] OP_LW  = 7'd3;
  localparam logic [6:0] OP_SW  = 7'd35;
  localparam logic [6:0] OP_BEQ = 7'd99;
  localparam logic [6:0] OP_JAL = 7'd111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_imm.sv
// Opcode to immediate-format select; purely combinational.
// Unknown opcodes fall back to the I format.
module imm_src_dec
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (opcode)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared-ALU multicycle RV32I datapath,
// with optional memory wait states, illegal trap and instret.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit ENABLE_JAL    = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_op,
  output logic [1:0]       imm_src,
  output logic             illegal,
  output logic             retire,
  output logic [CNT_W-1:0] instret
);

  statetype_e state, state_next;
  logic       rdy;
  logic       pc_update;
  logic       branch;
  logic       ill_q;

  assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  imm_src_dec u_imm (
    .opcode  (opcode),
    .imm_src (imm_src)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      ill_q   <= 1'b0;
      instret <= '0;
    end else begin
      state <= state_next;
      if (state_next == S_TRAP) ill_q <= 1'b1;
      if (retire) instret <= instret + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    result_src = RES_ALUOUT;
    alu_op     = ALU_ADD;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        ir_write   = rdy;
        pc_update  = rdy;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        if (rdy) state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = ENABLE_JAL ? S_JAL : S_TRAP;
          default:      state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        state_next = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (rdy) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
        retire    = rdy;
        if (rdy) state_next = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALU_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALU_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALU_SUB;
        branch     = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
    // Reset may land in any state; present a quiet FETCH cycle.
    if (reset) begin
      state_next = S_FETCH;
      mem_req    = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_update  = 1'b0;
      branch     = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      retire     = 1'b0;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_FOUR;
      result_src = RES_ALU;
      alu_op     = ALU_ADD;
    end
  end

  assign pc_write = pc_update | (branch & zero);
  assign illegal  = ill_q & ~reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: per-cycle expected control words queued with stimulus.
// Three instances: default, JAL disabled, 4-bit instret.
module tb_multicycle_controller;

  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] rs;
    logic [1:0] aop;
    logic       retire;
    logic       illegal;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic       rdy;
    logic       z;
    outs_t      e;
    string      tag;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mem_ready = 1'b1;
  logic       zero = 1'b0;
  logic [6:0] opcode = 7'd0;

  logic mem_req0, adr_src0, ir_write0, pc_write0, mem_write0;
  logic reg_write0, illegal0, retire0;
  logic [1:0] a0, b0, rs0, aop0, imm0;
  logic [31:0] instret0;
  logic mem_req1, adr_src1, ir_write1, pc_write1, mem_write1;
  logic reg_write1, illegal1, retire1;
  logic [1:0] a1, b1, rs1, aop1, imm1;
  logic [31:0] instret1;
  logic mem_req2, adr_src2, ir_write2, pc_write2, mem_write2;
  logic reg_write2, illegal2, retire2;
  logic [1:0] a2, b2, rs2, aop2, imm2;
  logic [3:0] instret2;

  outs_t o0, o1;
  ent_t  sb[$];
  int    checks = 0;
  int    errors = 0;

  assign o0 = {mem_req0, adr_src0, ir_write0, pc_write0, mem_write0,
               reg_write0, a0, b0, rs0, aop0, retire0, illegal0};
  assign o1 = {mem_req1, adr_src1, ir_write1, pc_write1, mem_write1,
               reg_write1, a1, b1, rs1, aop1, retire1, illegal1};

  always #5 clk = ~clk;

  multicycle_controller dut0 (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req0), .adr_src(adr_src0),
    .ir_write(ir_write0), .pc_write(pc_write0),
    .mem_write(mem_write0), .reg_write(reg_write0),
    .alu_src_a(a0), .alu_src_b(b0), .result_src(rs0),
    .alu_op(aop0), .imm_src(imm0), .illegal(illegal0),
    .retire(retire0), .instret(instret0)
  );

  multicycle_controller #(.ENABLE_JAL(1'b0)) dut1 (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req1), .adr_src(adr_src1),
    .ir_write(ir_write1), .pc_write(pc_write1),
    .mem_write(mem_write1), .reg_write(reg_write1),
    .alu_src_a(a1), .alu_src_b(b1), .result_src(rs1),
    .alu_op(aop1), .imm_src(imm1), .illegal(illegal1),
    .retire(retire1), .instret(instret1)
  );

  multicycle_controller #(.CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req2), .adr_src(adr_src2),
    .ir_write(ir_write2), .pc_write(pc_write2),
    .mem_write(mem_write2), .reg_write(reg_write2),
    .alu_src_a(a2), .alu_src_b(b2), .result_src(rs2),
    .alu_op(aop2), .imm_src(imm2), .illegal(illegal2),
    .retire(retire2), .instret(instret2)
  );

  function automatic outs_t mk(
    logic mr, logic ad, logic ir, logic pw, logic mw, logic rw,
    logic [1:0] a, logic [1:0] b, logic [1:0] rs, logic [1:0] aop,
    logic rt, logic il);
    return {mr, ad, ir, pw, mw, rw, a, b, rs, aop, rt, il};
  endfunction

  function automatic outs_t f_rst();
    return mk(0,0,0,0,0,0,2'b00,2'b10,2'b10,2'b00,0,0);
  endfunction
  function automatic outs_t f_fetch(logic r);
    return mk(1,0,r,r,0,0,2'b00,2'b10,2'b10,2'b00,0,0);
  endfunction
  function automatic outs_t f_dec();
    return mk(0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0,0);
  endfunction
  function automatic outs_t f_madr();
    return mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0,0);
  endfunction
  function automatic outs_t f_mrd();
    return mk(1,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0);
  endfunction
  function automatic outs_t f_mwb();
    return mk(0,0,0,0,0,1,2'b00,2'b00,2'b01,2'b00,1,0);
  endfunction
  function automatic outs_t f_mwr(logic r);
    return mk(1,1,0,0,1,0,2'b00,2'b00,2'b00,2'b00,r,0);
  endfunction
  function automatic outs_t f_exr();
    return mk(0,0,0,0,0,0,2'b10,2'b00,2'b00,2'b10,0,0);
  endfunction
  function automatic outs_t f_exi();
    return mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b10,0,0);
  endfunction
  function automatic outs_t f_aluwb();
    return mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,1,0);
  endfunction
  function automatic outs_t f_beq(logic z);
    return mk(0,0,0,z,0,0,2'b10,2'b00,2'b00,2'b01,1,0);
  endfunction
  function automatic outs_t f_jal();
    return mk(0,0,0,1,0,0,2'b01,2'b10,2'b00,2'b00,0,0);
  endfunction
  function automatic outs_t f_trap();
    return mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,1);
  endfunction

  function automatic void push(logic rst, logic [6:0] op, logic rdy,
                               logic z, outs_t e, string tag);
    ent_t n;
    n.rst = rst; n.op = op; n.rdy = rdy; n.z = z; n.e = e; n.tag = tag;
    sb.push_back(n);
  endfunction

  task automatic test_reset();
    ent_t e;
    push(1, 7'd0, 1, 0, f_rst(), "reset0");
    push(1, 7'd3, 0, 1, f_rst(), "reset1");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      reset = e.rst; opcode = e.op; mem_ready = e.rdy; zero = e.z;
      #1;
      checks++;
      if (o0 !== e.e) begin
        errors++;
        $display("FAIL %s got %h want %h", e.tag, o0, e.e);
      end
      @(negedge clk);
    end
    checks++;
    if (instret0 !== 32'd0) begin
      errors++;
      $display("FAIL reset_instret got %0d want 0", instret0);
    end
  endtask

  task automatic test_lw();
    ent_t e;
    push(0, 7'd3, 1, 0, f_fetch(1), "lw_fetch");
    push(0, 7'd3, 1, 0, f_dec(), "lw_decode");
    push(0, 7'd3, 1, 0, f_madr(), "lw_memadr");
    push(0, 7'd3, 1, 0, f_mrd(), "lw_memread");
    push(0, 7'd3, 1, 0, f_mwb(), "lw_memwb");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      reset = e.rst; opcode = e.op; mem_ready = e.rdy; zero = e.z;
      #1;
      checks++;
      if (o0 !== e.e) begin
        errors++;
        $display("FAIL %s got %h want %h", e.tag, o0, e.e);
      end
      @(negedge clk);
    end
    checks++;
    if (instret0 !== 32'd1) begin
      errors++;
      $display("FAIL lw_instret got %0d want 1", instret0);
    end
  endtask

  task automatic test_r_wait();
    ent_t e;
    repeat (3) push(0, 7'd51, 0, 0, f_fetch(0), "r_fetch_wait");
    push(0, 7'd51, 1, 0, f_fetch(1), "r_fetch_done");
    push(0, 7'd51, 0, 0, f_dec(), "r_decode");
    push(0, 7'd51, 0, 1, f_exr(), "r_exec");
    push(0, 7'd51, 0, 0, f_aluwb(), "r_aluwb");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      reset = e.rst; opcode = e.op; mem_ready = e.rdy; zero = e.z;
      #1;
      checks++;
      if (o0 !== e.e) begin
        errors++;
        $display("FAIL %s got %h want %h", e.tag, o0, e.e);
      end
      @(negedge clk);
    end
    checks++;
    if (instret0 !== 32'd2) begin
      errors++;
      $display("FAIL r_instret got %0d want 2", instret0);
    end
  endtask

  task automatic test_beq();
    ent_t e;
    push(0, 7'd99, 1, 1, f_fetch(1), "beq1_fetch");
    push(0, 7'd99, 1, 1, f_dec(), "beq1_decode");
    push(0, 7'd99, 1, 1, f_beq(1), "beq1_taken");
    push(0, 7'd99, 1, 0, f_fetch(1), "beq0_fetch");
    push(0, 7'd99, 1, 0, f_dec(), "beq0_decode");
    push(0, 7'd99, 1, 0, f_beq(0), "beq0_not_taken");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      reset = e.rst; opcode = e.op; mem_ready = e.rdy; zero = e.z;
      #1;
      checks++;
      if (o0 !== e.e) begin
        errors++;
        $display("FAIL %s got %h want %h", e.tag, o0, e.e);
      end
      @(negedge clk);
    end
    checks++;
    if (instret0 !== 32'd4 || imm0 !== 2'b10) begin
      errors++;
      $display("FAIL beq_instret_imm got %0d/%b want 4/10", instret0, imm0);
    end
  endtask

  task automatic test_sw_wait();
    ent_t e;
    push(0, 7'd35, 1, 0, f_fetch(1), "sw_fetch");
    push(0, 7'd35, 1, 0, f_dec(), "sw_decode");
    push(0, 7'd35, 1, 0, f_madr(), "sw_memadr");
    push(0, 7'd35, 0, 0, f_mwr(0), "sw_wait1");
    push(0, 7'd35, 0, 0, f_mwr(0), "sw_wait2");
    push(0, 7'd35, 1, 0, f_mwr(1), "sw_done");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      reset = e.rst; opcode = e.op; mem_ready = e.rdy; zero = e.z;
      #1;
      checks++;
      if (o0 !== e.e) begin
        errors++;
        $display("FAIL %s got %h want %h", e.tag, o0, e.e);
      end
      @(negedge clk);
    end
    checks++;
    if (instret0 !== 32'd5 || imm0 !== 2'b01) begin
      errors++;
      $display("FAIL sw_instret_imm got %0d/%b want 5/01", instret0, imm0);
    end
  endtask

  task automatic test_jal();
    ent_t  e;
    outs_t x1[4];
    x1[0] = f_fetch(1); x1[1] = f_dec(); x1[2] = f_trap(); x1[3] = f_trap();
    push(0, 7'd111, 1, 0, f_fetch(1), "jal_fetch");
    push(0, 7'd111, 1, 0, f_dec(), "jal_decode");
    push(0, 7'd111, 1, 0, f_jal(), "jal_jal");
    push(0, 7'd111, 1, 0, f_aluwb(), "jal_aluwb");
    for (int i = 0; i < 4; i++) begin
      e = sb.pop_front();
      reset = e.rst; opcode = e.op; mem_ready = e.rdy; zero = e.z;
      #1;
      checks++;
      if (o0 !== e.e) begin
        errors++;
        $display("FAIL %s got %h want %h", e.tag, o0, e.e);
      end
      checks++;
      if (o1 !== x1[i]) begin
        errors++;
        $display("FAIL nojal_%0d got %h want %h", i, o1, x1[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (instret0 !== 32'd6 || imm0 !== 2'b11) begin
      errors++;
      $display("FAIL jal_instret_imm got %0d/%b want 6/11", instret0, imm0);
    end
  endtask

  task automatic test_trap();
    ent_t e;
    push(0, 7'h7f, 1, 0, f_fetch(1), "trap_fetch");
    push(0, 7'h7f, 1, 0, f_dec(), "trap_decode");
    push(0, 7'h7f, 1, 0, f_trap(), "trap_enter");
    push(0, 7'h7f, 1, 1, f_trap(), "trap_hold");
    push(1, 7'h7f, 0, 0, f_rst(), "trap_reset");
    push(0, 7'd19, 0, 0, f_fetch(0), "trap_post_fetch");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      reset = e.rst; opcode = e.op; mem_ready = e.rdy; zero = e.z;
      #1;
      checks++;
      if (o0 !== e.e) begin
        errors++;
        $display("FAIL %s got %h want %h", e.tag, o0, e.e);
      end
      @(negedge clk);
    end
    checks++;
    if (instret0 !== 32'd0 || illegal1 !== 1'b0 || instret2 !== 4'd0) begin
      errors++;
      $display("FAIL trap_clear got %0d/%b/%0d want 0/0/0",
               instret0, illegal1, instret2);
    end
  endtask

  task automatic test_addi_wrap();
    ent_t       e;
    logic [3:0] want;
    for (int i = 0; i < 17; i++) begin
      push(0, 7'd19, 1, 0, f_fetch(1), "addi_fetch");
      push(0, 7'd19, 1, 0, f_dec(), "addi_decode");
      push(0, 7'd19, 1, 0, f_exi(), "addi_exec");
      push(0, 7'd19, 1, 0, f_aluwb(), "addi_aluwb");
      while (sb.size() > 0) begin
        e = sb.pop_front();
        reset = e.rst; opcode = e.op; mem_ready = e.rdy; zero = e.z;
        #1;
        checks++;
        if (o0 !== e.e || imm0 !== 2'b00) begin
          errors++;
          $display("FAIL %s_%0d got %h/%b want %h/00", e.tag, i, o0, imm0, e.e);
        end
        @(negedge clk);
      end
      want = 4'(i + 1);
      checks++;
      if (instret2 !== want) begin
        errors++;
        $display("FAIL wrap_%0d got %0d want %0d", i, instret2, want);
      end
    end
    checks++;
    if (instret0 !== 32'd17) begin
      errors++;
      $display("FAIL addi_instret got %0d want 17", instret0);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_r_wait();
    test_beq();
    test_sw_wait();
    test_jal();
    test_trap();
    test_addi_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control unit for the multicycle RV32I core; successor to the single-cycle opcode decoder.
- Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one unified memory.
- Adds I-type ALU, JAL, an optional variable-latency memory handshake, illegal-opcode trapping and a retired-instruction counter.
- Sits between the instruction register/flags and the datapath muxes and enables.

Parameters:
MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready ignored (treated as 1).
ENABLE_JAL, 1, 1 = opcode 111 (JAL) legal; 0 = JAL traps as illegal.
CNT_W, 32, width of the instret counter.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
opcode  in  7  instruction register [6:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
mem_req  out  1  memory access requested (FETCH, MEMREAD, MEMWRITE)
adr_src  out  1  0 = PC, 1 = ALU result (memory address)
ir_write  out  1  load instruction register
pc_write  out  1  pc_update | (branch & zero)
mem_write  out  1  memory write strobe
reg_write  out  1  register file write enable
alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1
alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4
result_src  out  2  00 = ALUOut, 01 = mem data, 10 = ALU result
alu_op  out  2  00 = add, 01 = sub/compare, 10 = funct decode
imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J (combinational from opcode, valid in all states)
illegal  out  1  sticky trap flag
retire  out  1  one-cycle pulse on instruction completion
instret  out  CNT_W  retired-instruction count

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset: state = FETCH, illegal = 0, instret = 0. While reset is high, ir_write, pc_write, mem_write, reg_write, retire and mem_req are forced to 0. Mux selects show their FETCH values.
- Opcodes: R = 51, I-ALU = 19, LW = 3, SW = 35, BEQ = 99, JAL = 111. Anything else is illegal.
- States, listing only non-zero outputs. Unlisted selects are 00 and unlisted enables are 0.
  - FETCH: mem_req, adr_src 0, ir_write, a = 00, b = 10, alu_op 00, result_src 10, pc_update. Goes to DECODE.
  - DECODE: a = 01, b = 01, alu_op 00. Next state by opcode:
    - LW/SW -> MEMADR
    - R -> EXECUTER
    - I -> EXECUTEI
    - BEQ -> BEQ
    - JAL -> JAL
    - else -> TRAP
  - MEMADR: a = 10, b = 01. Goes to MEMREAD if LW, MEMWRITE if SW.
  - MEMREAD: mem_req, adr_src 1. Goes to MEMWB.
  - MEMWB: result_src 01, reg_write. Goes to FETCH.
  - MEMWRITE: mem_req, adr_src 1, mem_write. Goes to FETCH.
  - EXECUTER: a = 10, b = 00, alu_op 10. Goes to ALUWB.
  - EXECUTEI: a = 10, b = 01, alu_op 10. Goes to ALUWB.
  - ALUWB: reg_write. Goes to FETCH.
  - BEQ: a = 10, b = 00, alu_op 01, branch. Goes to FETCH.
  - JAL: a = 01, b = 10, pc_update. Goes to ALUWB.
  - TRAP: all enables 0, illegal = 1. Absorbing; only reset exits.
- Handshake, when MEM_HANDSHAKE = 1:
  - FETCH, MEMREAD and MEMWRITE hold while mem_ready = 0.
  - mem_req and mem_write stay asserted for the whole wait.
  - ir_write and pc_update are asserted only in the cycle where mem_ready = 1, so PC and IR update exactly once per fetch.
- Latency with zero wait states:

| Instruction | Cycles |
|---|---|
| BEQ | 3 |
| R, I, SW | 4 |
| JAL | 4 |
| LW | 5 |

- retire pulses in:
  - MEMWB
  - the completing cycle of MEMWRITE
  - ALUWB
  - BEQ

  JAL retires in its ALUWB. instret increments on retire and wraps from 2^CNT_W−1 to 0.
- pc_write = pc_update | (branch & zero). If branch = 1 and zero = 0, pc_write = 0.
- Reset asserted mid-instruction, including during a memory wait or in TRAP: the next cycle is FETCH, no write enable is asserted in the reset cycle, and instret and illegal are cleared.
- illegal, once set, remains 1 until reset.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - the state enum statetype_e
  - opcode localparams (OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, OP_JAL)
  - select encodings for alu_src_a/b, result_src, alu_op and imm_src
- Sub-module imm_src_dec: combinational opcode -> imm_src, reused by the single-cycle core.
- FSM and counter stay in the top module.

Test Plan:
- Reset then LW, MEM_HANDSHAKE = 1, mem_ready = 1 always -> state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write = 1 and result_src = 01 only in cycle 5; instret = 1.
- R-type (opcode 51) with mem_ready low for 3 cycles in FETCH -> ir_write and pc_write high exactly once, in the 4th FETCH cycle; 7 cycles total; retire in ALUWB.
- BEQ (opcode 99), zero = 1, then again with zero = 0 -> pc_write = 1 in BEQ for the first, 0 for the second; both retire; instret = 2.
- SW (opcode 35) with 2 wait cycles in MEMWRITE -> mem_write high for 3 consecutive cycles, reg_write never high, one retire pulse.
- Opcode 0x7F, then reset asserted 2 cycles later -> illegal = 1 from TRAP entry and held; after reset, illegal = 0, instret = 0, state FETCH. Same test with ENABLE_JAL = 0 and opcode 111 -> TRAP.
- CNT_W = 4, run 17 ADDI (opcode 19) -> instret goes 15 -> 0 -> 1; each instruction takes 4 cycles with imm_src = 00.
